pmem_boot_loader: RTL and testbench

- Boot sequencer for the 8-bit core: streams a program image from a byte-wide valid/ready source into program memory through its load port (load_enable / load_address / load_instruction).
- Holds the core in reset until loading completes, then releases it.
- Sits between the external load link and the core top level; drives PMem load inputs and gates the core reset.

---
 rtl/pmem_boot_loader.sv | 117 +++++++++++
 tb/tb_pmem_boot_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_boot_loader.sv
// pmem_boot_loader: streams a COUNT/HI/LO byte image into program memory and holds the core in reset until done.
// Define PMEM_BOOT_CHECKSUM_EN to require a trailing XOR checksum byte after the last instruction.
module pmem_boot_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               pmem_le,
    output logic [ADDR_W-1:0]  pmem_addr,
    output logic [INSTR_W-1:0] pmem_instr,
    output logic               core_hold,
    output logic               busy,
    output logic               done,
    output logic               error
);
    typedef enum logic [2:0] {IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR} state_t;
    state_t     state;
    logic [8:0] remaining;
    logic [3:0] nibble;
    logic       xfer;
    assign xfer = in_valid & in_ready;
`ifdef PMEM_BOOT_CHECKSUM_EN
    logic [7:0] csum;
    always_ff @(posedge clk or negedge rst)
        if (!rst) csum <= '0;
        else if (state == LEN) csum <= '0;
        else if (xfer && (state == HI || state == LO)) csum <= csum ^ in_data;
`endif
    // pmem_addr doubles as the running write address; it only moves in WRITE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            remaining  <= '0;
            nibble     <= '0;
            in_ready   <= 1'b0;
            pmem_le    <= 1'b0;
            pmem_addr  <= '0;
            pmem_instr <= '0;
            core_hold  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            pmem_le <= 1'b0;
            case (state)
                IDLE, DONE, ERR: if (start) begin
                    state     <= LEN;
                    in_ready  <= 1'b1;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    error     <= 1'b0;
                    core_hold <= 1'b1;
                end
                LEN: if (xfer) begin
                    remaining <= {in_data == 8'd0, in_data};
                    pmem_addr <= '0;
                    state     <= HI;
                end
                HI: if (xfer) begin
                    if (in_data[7:4] != 4'd0) begin
                        state    <= ERR;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                    end else begin
                        nibble <= in_data[3:0];
                        state  <= LO;
                    end
                end
                LO: if (xfer) begin
                    pmem_instr <= INSTR_W'({nibble, in_data});
                    pmem_le    <= 1'b1;
                    in_ready   <= 1'b0;
                    state      <= WRITE;
                end
                WRITE: begin
                    remaining <= remaining - 9'd1;
                    if (remaining == 9'd1) begin
`ifdef PMEM_BOOT_CHECKSUM_EN
                        state    <= CHK;
                        in_ready <= 1'b1;
`else
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
`endif
                    end else begin
                        pmem_addr <= pmem_addr + ADDR_W'(1);
                        in_ready  <= 1'b1;
                        state     <= HI;
                    end
                end
`ifdef PMEM_BOOT_CHECKSUM_EN
                CHK: if (xfer) begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    if (in_data == csum) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                    end else begin
                        state <= ERR;
                        error <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_boot_loader.sv
// tb_pmem_boot_loader: table vectors, timing sequences and random images against a byte-stream reference model.
module tb_pmem_boot_loader;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, pmem_le, core_hold, busy, done, error;
    logic [7:0]  pmem_addr;
    logic [11:0] pmem_instr;

    int          n_cmp = 0, n_bad = 0, cyc = 0;
    int          n_used, s0, done_cyc;
    bit          exp_done, exp_err;
    logic [19:0] wq[$], exp_w[$];
    int          lq[$];
    logic [7:0]  img[$];

    typedef struct {
        int         len;
        logic [7:0] b [7];
        int         gap;
        bit         exp_done;
        bit         exp_err;
        int         exp_nw;
    } vec_t;
    vec_t tbl [6];

    pmem_boot_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .pmem_le(pmem_le), .pmem_addr(pmem_addr), .pmem_instr(pmem_instr),
        .core_hold(core_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (pmem_le) begin
        wq.push_back({pmem_addr, pmem_instr});
        lq.push_back(cyc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_pmem_le"}, pmem_le, 0);
        chk({tag, "_pmem_addr"}, pmem_addr, 0);
        chk({tag, "_pmem_instr"}, pmem_instr, 0);
        chk({tag, "_core_hold"}, core_hold, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    // Reference: walk the image byte by byte and list the writes it must cause.
    task automatic model();
        int cnt, k;
        logic [7:0] cs;
        exp_w.delete();
        exp_done = 0;
        exp_err = 0;
        cs = '0;
        cnt = (img[0] == 8'd0) ? 256 : int'(img[0]);
        k = 1;
        for (int i = 0; i < cnt; i++) begin
            if (img[k][7:4] != 4'd0) begin
                exp_err = 1;
                n_used = k + 1;
                return;
            end
            exp_w.push_back({8'(i), img[k][3:0], img[k+1]});
            cs ^= img[k] ^ img[k+1];
            k += 2;
        end
`ifdef PMEM_BOOT_CHECKSUM_EN
        exp_done = (img[k] == cs);
        exp_err = !exp_done;
        k++;
`else
        exp_done = 1;
`endif
        n_used = k;
    endtask

`ifdef PMEM_BOOT_CHECKSUM_EN
    task automatic add_cs(input bit good);
        logic [7:0] cs = '0;
        for (int i = 1; i < img.size(); i++) cs ^= img[i];
        img.push_back(good ? cs : cs ^ 8'($urandom_range(1, 255)));
    endtask
`endif

    task automatic do_start();
        start = 1'b1;
        s0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int t = 0;
        repeat (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data = b;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        done_cyc = cyc;
        chk("busy_timeout", busy, 0);
    endtask

    task automatic run_image(input int gap, input int start_at);
        bit ok;
        model();
        wq.delete();
        lq.delete();
        do_start();
        chk("start_hold", core_hold, 1);
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_err", error, 0);
        for (int i = 0; i < n_used; i++) begin
            if (i == start_at) start = 1'b1;
            send_byte(img[i], gap, ok);
            start = 1'b0;
            chk("byte_accept", ok, 1);
            if (!ok) break;
        end
        wait_idle();
        repeat (2) @(negedge clk);
        chk("done", done, exp_done);
        chk("error", error, exp_err);
        chk("core_hold", core_hold, !exp_done);
        chk("in_ready_end", in_ready, 0);
        chk("n_writes", wq.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wq.size(); i++) chk("write", wq[i], exp_w[i]);
    endtask

    initial begin
        bit ok;
        tbl[0] = '{5, '{8'h02, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h00, 8'h00}, 0, 1'b1, 1'b0, 2};
        tbl[1] = '{5, '{8'h02, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h00, 8'h00}, 3, 1'b1, 1'b0, 2};
        tbl[2] = '{2, '{8'h01, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b0, 1'b1, 0};
        tbl[3] = '{3, '{8'h01, 8'h05, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 1'b1, 1'b0, 1};
        tbl[4] = '{5, '{8'h02, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00}, 1, 1'b1, 1'b0, 2};
        tbl[5] = '{4, '{8'h02, 8'h03, 8'h44, 8'h80, 8'h00, 8'h00, 8'h00}, 0, 1'b0, 1'b1, 1};

        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk_reset("idle");
        chk("idle_no_le", wq.size(), 0);

        img = '{8'h02, 8'h0A, 8'hBC, 8'h01, 8'h23};
`ifdef PMEM_BOOT_CHECKSUM_EN
        add_cs(1);
`endif
        run_image(0, -1);
        if (lq.size() >= 2) begin
            chk("le0_cycle", lq[0] - s0, 4);
            chk("le1_cycle", lq[1] - s0, 7);
        end
`ifndef PMEM_BOOT_CHECKSUM_EN
        chk("done_cycle", done_cyc - s0, 8);
`endif

        for (int v = 0; v < 6; v++) begin
            img.delete();
            for (int j = 0; j < tbl[v].len; j++) img.push_back(tbl[v].b[j]);
`ifdef PMEM_BOOT_CHECKSUM_EN
            add_cs(1);
`endif
            run_image(tbl[v].gap, -1);
            chk("tbl_done", done, tbl[v].exp_done);
            chk("tbl_err", error, tbl[v].exp_err);
            chk("tbl_nw", wq.size(), tbl[v].exp_nw);
        end

        img = '{8'h00};
        for (int i = 0; i < 256; i++) begin
            img.push_back({4'h0, 4'($urandom)});
            img.push_back(8'($urandom));
        end
`ifdef PMEM_BOOT_CHECKSUM_EN
        add_cs(1);
`endif
        run_image(0, 101);
        if (wq.size() == 256) chk("last_addr", wq[255][19:12], 8'hFF);

        for (int r = 0; r < 40; r++) begin
            int cnt = $urandom_range(1, 6);
            img = '{8'(cnt)};
            for (int i = 0; i < cnt; i++) begin
                img.push_back(($urandom_range(0, 9) == 0) ? {4'($urandom_range(1, 15)), 4'($urandom)}
                                                          : {4'h0, 4'($urandom)});
                img.push_back(8'($urandom));
            end
`ifdef PMEM_BOOT_CHECKSUM_EN
            add_cs($urandom_range(0, 3) != 0);
`endif
            run_image($urandom_range(0, 2), $urandom_range(0, 12));
        end

`ifdef PMEM_BOOT_CHECKSUM_EN
        img = '{8'h01, 8'h0A, 8'hBC, 8'hB6};
        run_image(0, -1);
        chk("cs_good_done", done, 1);
        img = '{8'h01, 8'h0A, 8'hBC, 8'h00};
        run_image(0, -1);
        chk("cs_bad_err", error, 1);
        chk("cs_bad_hold", core_hold, 1);
        chk("cs_bad_nw", wq.size(), 1);
`endif

        img = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        do_start();
        for (int i = 0; i < 3; i++) send_byte(img[i], 0, ok);
        #2 rst = 1'b0;
        #1 chk_reset("async");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
